// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch front end with PC-tagged instruction FIFO
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         mem_req_o,
    output logic [31:0]                  mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [31:0]                  mem_data_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    output logic                         instr_valid_o,
    output logic [31:0]                  instr_o,
    output logic [31:0]                  instr_pc_o,
    input  logic                         instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   addr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic [CW-1:0] count_pop;
    logic [31:0]   addr_inc;
    logic [31:0]   redirect_pc_al;

    // Handshake decode; a redirect voids both the push and the consumer pop of its cycle
    always_comb begin
        redirect_pc_al = redirect_pc_i & 32'hFFFF_FFFC;
        instr_valid_o  = (count != '0);
        pop            = instr_valid_o && instr_ready_i && !redirect_i;
        push           = (state == ST_WAIT) && mem_ack_i && !redirect_i;
        count_pop      = count - CW'(pop);
        addr_inc       = addr + 32'd4;
        mem_req_o      = (state == ST_WAIT) || (state == ST_DISCARD);
        mem_addr_o     = addr;
        instr_o        = instr_valid_o ? instr_mem[rd_ptr] : 32'd0;
        instr_pc_o     = instr_valid_o ? pc_mem[rd_ptr]    : 32'd0;
        count_o        = count;
    end

    // Fetch sequencer: one outstanding request, chained back to back while the queue has room
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            addr     <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_pc_al;
                    end else if (count_pop < DEPTH_C) begin
                        addr  <= fetch_pc;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_pc_al;
                        state    <= mem_ack_i ? ST_IDLE : ST_DISCARD;
                    end else if (mem_ack_i) begin
                        fetch_pc <= addr_inc;
                        // the slot just filled counts against room for the next request
                        if (count_pop < DEPTH_M1) begin
                            addr <= addr_inc;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_pc_al;
                    end
                    if (mem_ack_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Queue bookkeeping; a redirect empties the queue by snapping the read pointer to the write pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_pop + CW'(push);
        end
    end

    // Queue storage: returned instruction tagged with the address it was fetched from
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= addr;
            instr_mem[wr_ptr] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic [2:0]  count_o;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // memory content is a fixed function of the word address
    assign mem_data_i = mem_addr_o ^ XORK;

    int          n_total = 0;
    int          n_pass  = 0;
    int          mem_wait_mode = 0;   // -1: random 0..3 wait cycles
    int          wait_left = 0;
    int          pop_count = 0;
    int          max_count = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, expv);
    endtask

    // program-order model: after reset/redirect the consumer sees start, start+4, ...
    task automatic flush_model(input logic [31:0] pc);
        exp_q.delete();
        model_pc = pc & 32'hFFFF_FFFC;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        flush_model(pc);
        cyc();
        redirect_i = 1'b0;
    endtask

    task automatic wait_req(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            #1;
            if (mem_req_o) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, found, 32'(found), 32'd1);
    endtask

    // memory model: per-request wait count, ack held until the request completes
    initial begin
        bit completed;
        mem_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            completed = mem_ack_i && mem_req_o;
            if (completed || rst_i)
                wait_left = (mem_wait_mode < 0) ? int'($urandom_range(0, 3)) : mem_wait_mode;
            #1;
            if (mem_req_o && wait_left == 0) begin
                mem_ack_i = 1'b1;
            end else begin
                mem_ack_i = 1'b0;
                if (mem_req_o) wait_left--;
            end
        end
    end

    // monitor: pops the expected stream on every accepted instruction, plus protocol invariants
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_pend = 1'b0;
            end else begin
                if (!instr_valid_o)
                    check("empty_outputs_zero", instr_o == 0 && instr_pc_o == 0, instr_o | instr_pc_o, 32'd0);
                check("count_bound", count_o <= DEPTH, 32'(count_o), DEPTH);
                if (instr_valid_o && instr_ready_i && !redirect_i) begin
                    while (exp_q.size() < 4) begin
                        exp_q.push_back(model_pc);
                        model_pc = model_pc + 32'd4;
                    end
                    e = exp_q.pop_front();
                    check("pop_pc", instr_pc_o == e, instr_pc_o, e);
                    check("pop_instr", instr_o == (e ^ XORK), instr_o, e ^ XORK);
                    pop_count++;
                end
                if (prev_pend)
                    check("req_hold", mem_req_o && mem_addr_o == prev_addr, mem_req_o ? mem_addr_o : 32'hDEAD_0000, prev_addr);
                prev_pend = mem_req_o && !mem_ack_i;
                prev_addr = mem_addr_o;
                if (int'(count_o) > max_count) max_count = int'(count_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bit          found;
        logic [31:0] old_addr;
        rst_i = 1'b1; instr_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        flush_model(RPC);
        repeat (3) cyc();
        #1;
        check("rst_req", mem_req_o == 0, 32'(mem_req_o), 32'd0);
        check("rst_valid", instr_valid_o == 0, 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o == 0, instr_o, 32'd0);
        check("rst_pc", instr_pc_o == 0, instr_pc_o, 32'd0);
        check("rst_count", count_o == 0, 32'(count_o), 32'd0);

        // zero-wait memory, always-ready consumer, PC wraps through zero
        cyc();
        rst_i = 1'b0;
        #1;
        check("first_cycle_idle", mem_req_o == 0, 32'(mem_req_o), 32'd0);
        cyc(); #1;
        check("first_req", mem_req_o == 1, 32'(mem_req_o), 32'd1);
        check("first_addr", mem_addr_o == RPC, mem_addr_o, RPC);
        cyc(); #1;
        check("first_valid", instr_valid_o == 1, 32'(instr_valid_o), 32'd1);
        check("first_instr_pc", instr_pc_o == RPC, instr_pc_o, RPC);
        pop_count = 0;
        max_count = 0;
        repeat (20) cyc();
        check("stream_max_count", max_count <= 1, 32'(max_count), 32'd1);
        check("stream_throughput", pop_count == 20, 32'(pop_count), 32'd20);

        // stalled consumer fills the queue, then drains in order and fetch resumes at 16
        instr_ready_i = 1'b0;
        do_redirect(32'h0000_0000);
        repeat (12) cyc();
        #1;
        check("full_count", count_o == 4, 32'(count_o), 32'd4);
        check("full_no_req", mem_req_o == 0, 32'(mem_req_o), 32'd0);
        check("full_head_pc", instr_pc_o == 0, instr_pc_o, 32'd0);
        check("full_head_instr", instr_o == XORK, instr_o, XORK);
        instr_ready_i = 1'b1;
        wait_req("resume", found);
        check("resume_addr", mem_addr_o == 32'd16, mem_addr_o, 32'd16);

        // redirect during the second wait cycle of a 3-wait request
        instr_ready_i = 1'b0;
        mem_wait_mode = 3;
        do_redirect(32'h0000_0200);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(); #1;
            if (mem_req_o && mem_addr_o == 32'h200) begin found = 1'b1; break; end
        end
        check("discard_setup_timeout", found, 32'(found), 32'd1);
        old_addr = mem_addr_o;
        cyc();
        do_redirect(32'h0000_0103);
        #1;
        check("discard_req_held", mem_req_o == 1, 32'(mem_req_o), 32'd1);
        for (int i = 0; i < 10 && mem_req_o; i++) begin
            check("discard_addr_hold", mem_addr_o == old_addr, mem_addr_o, old_addr);
            cyc(); #1;
        end
        check("discard_released", mem_req_o == 0, 32'(mem_req_o), 32'd0);
        wait_req("after_discard", found);
        check("after_discard_addr", mem_addr_o == 32'h100, mem_addr_o, 32'h100);
        instr_ready_i = 1'b1;
        repeat (12) cyc();

        // redirect and ack together with two entries queued and a pop offered
        mem_wait_mode = 0;
        instr_ready_i = 1'b0;
        do_redirect(32'h0000_0400);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (count_o == 2) begin found = 1'b1; break; end
        end
        check("cnt2_setup_timeout", found, 32'(found), 32'd1);
        check("cnt2_ack_same_cycle", mem_req_o && mem_ack_i, 32'(mem_ack_i), 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0800; instr_ready_i = 1'b1;
        flush_model(32'h0000_0800);
        cyc();
        redirect_i = 1'b0;
        #1;
        check("flush_count", count_o == 0, 32'(count_o), 32'd0);
        check("flush_valid", instr_valid_o == 0, 32'(instr_valid_o), 32'd0);
        repeat (10) cyc();

        // randomized consumer, memory latency and redirects
        mem_wait_mode = -1;
        for (int i = 0; i < 600; i++) begin
            instr_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom();
                flush_model(redirect_pc_i);
            end else begin
                redirect_i = 1'b0;
            end
            cyc();
        end
        redirect_i = 1'b0;
        instr_ready_i = 1'b1;
        repeat (20) cyc();

        // reset while a request is outstanding and three entries are queued
        instr_ready_i = 1'b0;
        mem_wait_mode = 2;
        do_redirect(32'h0000_1000);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(); #1;
            if (count_o == 3 && mem_req_o) begin found = 1'b1; break; end
        end
        check("rst_wait_setup_timeout", found, 32'(found), 32'd1);
        rst_i = 1'b1;
        flush_model(RPC);
        cyc();
        rst_i = 1'b0;
        #1;
        check("rst2_req", mem_req_o == 0, 32'(mem_req_o), 32'd0);
        check("rst2_valid", instr_valid_o == 0, 32'(instr_valid_o), 32'd0);
        check("rst2_instr", instr_o == 0, instr_o, 32'd0);
        check("rst2_pc", instr_pc_o == 0, instr_pc_o, 32'd0);
        check("rst2_count", count_o == 0, 32'(count_o), 32'd0);
        wait_req("rst2_restart", found);
        check("rst2_restart_addr", mem_addr_o == RPC, mem_addr_o, RPC);
        instr_ready_i = 1'b1;
        pop_count = 0;
        repeat (15) cyc();
        check("rst2_pops_seen", pop_count >= 3, 32'(pop_count), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
